// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1xn
// Brief    : Registered 1-to-N valid/ready stream demux with direct,
//            broadcast and round-robin routing plus a saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1xn #(
    parameter int N_OUT  = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic [SEL_W-1:0]        s_sel,
    output logic [N_OUT-1:0]        m_valid,
    input  logic [N_OUT-1:0]        m_ready,
    output logic [N_OUT*DATA_W-1:0] m_data,
    output logic [SEL_W-1:0]        rr_ptr,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam logic [1:0]       c_mode_direct = 2'b00;
    localparam logic [1:0]       c_mode_bcast  = 2'b01;
    localparam logic [1:0]       c_mode_rr     = 2'b10;
    localparam logic [SEL_W:0]   c_n_out       = (SEL_W+1)'(N_OUT);
    localparam logic [SEL_W-1:0] c_rr_last     = SEL_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    logic [N_OUT-1:0]  w_free;
    logic [N_OUT-1:0]  w_sel_hot;
    logic [N_OUT-1:0]  w_rr_hot;
    logic [N_OUT-1:0]  w_target;
    logic [N_OUT-1:0]  w_load;
    logic              w_sel_ok;
    logic              w_drop;
    logic              w_accept;
    logic [N_OUT-1:0]  r_valid;
    logic [DATA_W-1:0] r_data [N_OUT];
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_drop_cnt;

    // A channel may be refilled in the same cycle its consumer drains it.
    assign w_free   = ~r_valid | m_ready;
    assign w_sel_ok = ({1'b0, s_sel} < c_n_out);

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_decode
            assign w_sel_hot[k] = (s_sel == SEL_W'(k));
            assign w_rr_hot[k]  = (r_rr_ptr == SEL_W'(k));
        end
    endgenerate

    // s_ready is derived without s_valid so producers may wait on it.
    always_comb begin
        s_ready  = 1'b0;
        w_target = '0;
        w_drop   = 1'b0;
        case (mode)
            c_mode_direct: begin
                if (w_sel_ok) begin
                    s_ready  = |(w_sel_hot & w_free);
                    w_target = w_sel_hot;
                end else begin
                    s_ready = 1'b1;
                    w_drop  = 1'b1;
                end
            end
            c_mode_bcast: begin
                s_ready  = &w_free;
                w_target = '1;
            end
            c_mode_rr: begin
                s_ready  = |(w_rr_hot & w_free);
                w_target = w_rr_hot;
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

    assign w_accept = s_valid & s_ready;
    assign w_load   = w_accept ? w_target : '0;

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_chan
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end else if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= s_data;
                end else if (m_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            assign m_data[k*DATA_W +: DATA_W] = r_data[k];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept && (mode == c_mode_rr)) begin
            r_rr_ptr <= (r_rr_ptr == c_rr_last) ? '0 : r_rr_ptr + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_drop && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign m_valid  = r_valid;
    assign rr_ptr   = r_rr_ptr;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1xn
// Brief    : Directed vector bench for stream_demux_1xn (8- and 6-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst_n;

    logic [1:0]  mode;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [3:0]  s_sel;
    logic [7:0]  m_valid;
    logic [7:0]  m_ready;
    logic [63:0] m_data;
    logic [3:0]  rr_ptr;
    logic [7:0]  drop_cnt;

    logic [1:0]  mode6;
    logic        s_valid6;
    logic        s_ready6;
    logic [7:0]  s_data6;
    logic [2:0]  s_sel6;
    logic [5:0]  m_valid6;
    logic [5:0]  m_ready6;
    logic [47:0] m_data6;
    logic [2:0]  rr_ptr6;
    logic [7:0]  drop_cnt6;

    int checks;
    int failures;

    stream_demux_1xn #(.N_OUT(8), .DATA_W(8), .SEL_W(4), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
    );

    stream_demux_1xn #(.N_OUT(6), .DATA_W(8), .SEL_W(3), .CNT_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .s_valid(s_valid6),
        .s_ready(s_ready6), .s_data(s_data6), .s_sel(s_sel6),
        .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
        .rr_ptr(rr_ptr6), .drop_cnt(drop_cnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       vld;
        logic [7:0] data;
        logic [3:0] sel;
        logic [7:0] rdy;
        logic       exp_srdy;
        logic [7:0] exp_mvld;
        int         exp_ch;
        logic [7:0] exp_data;
        logic [3:0] exp_rr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] md, input logic v, input logic [7:0] d,
                         input logic [3:0] sl, input logic [7:0] rdy);
        mode    = md;
        s_valid = v;
        s_data  = d;
        s_sel   = sl;
        m_ready = rdy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(2'b00, 1'b0, 8'h00, 4'h0, 8'h00);
        mode6 = 2'b00; s_valid6 = 1'b0; s_data6 = 8'h00; s_sel6 = 3'd0; m_ready6 = 6'h00;

        // Direct sweep: sel 0..7, data A0+sel, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{2'b00, 1'b1, 8'hA0 + 8'(i), 4'(i), 8'hFF,
                        1'b1, 8'h01 << i, i, 8'hA0 + 8'(i), 4'h0};
        end
        // Round-robin: 10 beats 00..09 land on channels 0..7,0,1.
        for (int i = 0; i < 10; i++) begin
            vecs[8+i] = '{2'b10, 1'b1, 8'(i), 4'h0, 8'hFF,
                          1'b1, 8'h01 << (i % 8), i % 8, 8'(i), 4'((i + 1) % 8)};
        end

        tick();
        tick();
        check("reset_m_valid",  {56'h0, m_valid}, 64'h0);
        check("reset_m_data",   m_data, 64'h0);
        check("reset_rr_ptr",   {60'h0, rr_ptr}, 64'h0);
        check("reset_drop_cnt", {56'h0, drop_cnt}, 64'h0);
        check("reset_m_valid6", {58'h0, m_valid6}, 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].mode, vecs[i].vld, vecs[i].data, vecs[i].sel, vecs[i].rdy);
            #1;
            check("vec_s_ready", {63'h0, s_ready}, {63'h0, vecs[i].exp_srdy});
            tick();
            check("vec_m_valid", {56'h0, m_valid}, {56'h0, vecs[i].exp_mvld});
            check("vec_m_data",  {56'h0, m_data[vecs[i].exp_ch*8 +: 8]}, {56'h0, vecs[i].exp_data});
            check("vec_rr_ptr",  {60'h0, rr_ptr}, {60'h0, vecs[i].exp_rr});
        end
        // rr_ptr=2, channel 1 holds 09 and drains below.

        // Direct backpressure on channel 3.
        drive(2'b00, 1'b1, 8'h11, 4'd3, 8'hF7);
        #1;
        check("bp_first_ready", {63'h0, s_ready}, 64'h1);
        tick();
        check("bp_first_valid", {56'h0, m_valid}, 64'h08);
        check("bp_first_data",  {56'h0, m_data[3*8 +: 8]}, 64'h11);
        drive(2'b00, 1'b1, 8'h22, 4'd3, 8'hF7);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("bp_stall_ready", {63'h0, s_ready}, 64'h0);
            tick();
            check("bp_hold_data", {56'h0, m_data[3*8 +: 8]}, 64'h11);
            check("bp_hold_valid", {56'h0, m_valid}, 64'h08);
        end
        m_ready = 8'hFF;
        #1;
        check("bp_drain_ready", {63'h0, s_ready}, 64'h1);
        tick();
        check("bp_second_valid", {56'h0, m_valid}, 64'h08);
        check("bp_second_data",  {56'h0, m_data[3*8 +: 8]}, 64'h22);
        drive(2'b00, 1'b0, 8'h00, 4'd0, 8'hFF);
        tick();
        check("bp_empty", {56'h0, m_valid}, 64'h0);

        // Broadcast blocked by a stalled channel 6.
        drive(2'b00, 1'b1, 8'h66, 4'd6, 8'hBF);
        tick();
        drive(2'b01, 1'b1, 8'h5A, 4'd0, 8'hBF);
        #1;
        check("bc_blocked_ready", {63'h0, s_ready}, 64'h0);
        tick();
        check("bc_no_partial", {56'h0, m_valid}, 64'h40);
        check("bc_ch6_held", {56'h0, m_data[6*8 +: 8]}, 64'h66);
        m_ready = 8'hFF;
        #1;
        check("bc_open_ready", {63'h0, s_ready}, 64'h1);
        tick();
        check("bc_all_valid", {56'h0, m_valid}, 64'hFF);
        check("bc_all_data", m_data, 64'h5A5A_5A5A_5A5A_5A5A);
        check("bc_rr_hold", {60'h0, rr_ptr}, 64'h2);
        drive(2'b00, 1'b0, 8'h00, 4'd0, 8'hFF);
        tick();

        // Out-of-range direct select on the 8-channel instance.
        drive(2'b00, 1'b1, 8'hEE, 4'd9, 8'hFF);
        #1;
        check("drop8_ready", {63'h0, s_ready}, 64'h1);
        tick();
        drive(2'b00, 1'b1, 8'hEE, 4'd15, 8'hFF);
        tick();
        check("drop8_cnt", {56'h0, drop_cnt}, 64'h2);
        check("drop8_no_valid", {56'h0, m_valid}, 64'h0);
        drive(2'b00, 1'b0, 8'h00, 4'd0, 8'hFF);

        // 6-channel instance: select 7 drops, then saturation.
        mode6 = 2'b00; s_valid6 = 1'b1; s_data6 = 8'h77; s_sel6 = 3'd7; m_ready6 = 6'h3F;
        #1;
        check("drop6_ready", {63'h0, s_ready6}, 64'h1);
        for (int c = 0; c < 3; c++) tick();
        check("drop6_cnt3", {56'h0, drop_cnt6}, 64'd3);
        check("drop6_no_valid", {58'h0, m_valid6}, 64'h0);
        for (int c = 0; c < 297; c++) tick();
        check("drop6_sat", {56'h0, drop_cnt6}, 64'd255);
        s_sel6 = 3'd6;
        tick();
        check("drop6_sel6_sat", {56'h0, drop_cnt6}, 64'd255);
        check("drop6_sel6_novalid", {58'h0, m_valid6}, 64'h0);
        s_sel6 = 3'd5; s_data6 = 8'h55;
        tick();
        check("dir6_ch5_valid", {58'h0, m_valid6}, 64'h20);
        check("dir6_ch5_data", {56'h0, m_data6[5*8 +: 8]}, 64'h55);
        s_valid6 = 1'b0;
        tick();

        // Hold channels 2 and 5, rr_ptr to 4, then async reset mid-cycle.
        drive(2'b00, 1'b1, 8'hC5, 4'd5, 8'hDB);
        tick();
        drive(2'b10, 1'b1, 8'hC2, 4'd0, 8'hDB);
        tick();
        drive(2'b10, 1'b1, 8'hC3, 4'd0, 8'hDB);
        tick();
        drive(2'b00, 1'b0, 8'h00, 4'd0, 8'hDB);
        tick();
        check("pre_rst_valid", {56'h0, m_valid}, 64'h24);
        check("pre_rst_rr", {60'h0, rr_ptr}, 64'h4);
        check("pre_rst_ch2", {56'h0, m_data[2*8 +: 8]}, 64'hC2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {56'h0, m_valid}, 64'h0);
        check("async_rst_rr", {60'h0, rr_ptr}, 64'h0);
        check("async_rst_drop", {56'h0, drop_cnt}, 64'h0);
        check("async_rst_data", m_data, 64'h0);
        check("async_rst_drop6", {56'h0, drop_cnt6}, 64'h0);
        tick();
        rst_n = 1'b1;
        drive(2'b11, 1'b1, 8'h99, 4'd0, 8'hFF);
        #1;
        check("rsvd_ready", {63'h0, s_ready}, 64'h0);
        tick();
        check("rsvd_no_valid", {56'h0, m_valid}, 64'h0);
        check("rsvd_rr", {60'h0, rr_ptr}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
